// File: rtl/pixel_readout_sequencer.sv
// Frame sequencer for a pixel array: erase, expose, ADC ramp, then row-major group readout.
// Optional macro ROI_EN restricts readout to a latched row/group rectangle.
module pixel_readout_sequencer #(
    parameter int unsigned PIXEL_ARRAY_HEIGHT = 128,
    parameter int unsigned PIXEL_ARRAY_WIDTH  = 128,
    parameter int unsigned PIXEL_BITS         = 8,
    parameter int unsigned OUTPUT_BUS_WIDTH   = 8,
    parameter int unsigned EXPOSE_CNT_W       = 16,
    localparam int unsigned ROW_W  = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
    localparam int unsigned GROUPS = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH,
    localparam int unsigned GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    localparam int unsigned DATA_W = OUTPUT_BUS_WIDTH * PIXEL_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [EXPOSE_CNT_W-1:0] expose_cycles,
`ifdef ROI_EN
    input  logic [ROW_W-1:0]        roi_row_first,
    input  logic [ROW_W-1:0]        roi_row_last,
    input  logic [GRP_W-1:0]        roi_grp_first,
    input  logic [GRP_W-1:0]        roi_grp_last,
`endif
    output logic                    erase,
    output logic                    expose,
    output logic                    convert,
    output logic [PIXEL_BITS-1:0]   adc_count,
    output logic [ROW_W-1:0]        row_select,
    output logic [GRP_W-1:0]        col_group,
    output logic                    read_en,
    input  logic [DATA_W-1:0]       pix_data,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sof,
    output logic                    out_eol,
    output logic                    out_eof,
    output logic                    busy,
    output logic                    frame_done
);

    if ((PIXEL_ARRAY_WIDTH % OUTPUT_BUS_WIDTH) != 0) begin : g_width_check
        $error("PIXEL_ARRAY_WIDTH must be a multiple of OUTPUT_BUS_WIDTH");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_DONE
    } state_t;

    state_t                  r_state;
    logic [EXPOSE_CNT_W-1:0] r_exp_cnt;
    logic                    r_addr_left;
    logic [ROW_W-1:0]        w_row_first, w_row_last;
    logic [GRP_W-1:0]        w_grp_first, w_grp_last;
    logic                    w_read_en;

`ifdef ROI_EN
    logic [ROW_W-1:0] r_row_first, r_row_last;
    logic [GRP_W-1:0] r_grp_first, r_grp_last;
    logic             w_roi_ok;

    // A malformed or out-of-array window falls back to the full frame.
    assign w_roi_ok = (roi_row_first <= roi_row_last)
                   && (roi_row_last <= ROW_W'(PIXEL_ARRAY_HEIGHT - 1))
                   && (roi_grp_first <= roi_grp_last)
                   && (roi_grp_last <= GRP_W'(GROUPS - 1));

    assign w_row_first = r_row_first;
    assign w_row_last  = r_row_last;
    assign w_grp_first = r_grp_first;
    assign w_grp_last  = r_grp_last;
`else
    assign w_row_first = '0;
    assign w_row_last  = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
    assign w_grp_first = '0;
    assign w_grp_last  = GRP_W'(GROUPS - 1);
`endif

    // Fetch whenever the one-deep output register is empty or draining this cycle.
    assign w_read_en = (r_state == S_READ) && r_addr_left && (!out_valid || out_ready);
    assign read_en   = w_read_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_exp_cnt   <= '0;
            r_addr_left <= 1'b0;
            erase       <= 1'b0;
            expose      <= 1'b0;
            convert     <= 1'b0;
            adc_count   <= '0;
            row_select  <= '0;
            col_group   <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eol     <= 1'b0;
            out_eof     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
`ifdef ROI_EN
            r_row_first <= '0;
            r_row_last  <= '0;
            r_grp_first <= '0;
            r_grp_last  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_ERASE;
                        erase     <= 1'b1;
                        busy      <= 1'b1;
                        r_exp_cnt <= (expose_cycles == '0) ? '0
                                   : expose_cycles - EXPOSE_CNT_W'(1);
`ifdef ROI_EN
                        r_row_first <= w_roi_ok ? roi_row_first : '0;
                        r_row_last  <= w_roi_ok ? roi_row_last  : ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
                        r_grp_first <= w_roi_ok ? roi_grp_first : '0;
                        r_grp_last  <= w_roi_ok ? roi_grp_last  : GRP_W'(GROUPS - 1);
`endif
                    end
                end
                S_ERASE: begin
                    r_state <= S_EXPOSE;
                    erase   <= 1'b0;
                    expose  <= 1'b1;
                end
                S_EXPOSE: begin
                    if (r_exp_cnt == '0) begin
                        r_state <= S_CONVERT;
                        expose  <= 1'b0;
                        convert <= 1'b1;
                    end else begin
                        r_exp_cnt <= r_exp_cnt - EXPOSE_CNT_W'(1);
                    end
                end
                S_CONVERT: begin
                    if (adc_count == '1) begin
                        r_state     <= S_READ;
                        convert     <= 1'b0;
                        adc_count   <= '0;
                        row_select  <= w_row_first;
                        col_group   <= w_grp_first;
                        r_addr_left <= 1'b1;
                    end else begin
                        adc_count <= adc_count + PIXEL_BITS'(1);
                    end
                end
                S_READ: begin
                    if (w_read_en) begin
                        out_data  <= pix_data;
                        out_valid <= 1'b1;
                        out_sof   <= (row_select == w_row_first) && (col_group == w_grp_first);
                        out_eol   <= (col_group == w_grp_last);
                        out_eof   <= (row_select == w_row_last) && (col_group == w_grp_last);
                        if (col_group == w_grp_last) begin
                            col_group <= w_grp_first;
                            if (row_select == w_row_last) begin
                                r_addr_left <= 1'b0;
                            end else begin
                                row_select <= row_select + ROW_W'(1);
                            end
                        end else begin
                            col_group <= col_group + GRP_W'(1);
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_sof   <= 1'b0;
                        out_eol   <= 1'b0;
                        out_eof   <= 1'b0;
                        if (!r_addr_left) begin
                            r_state    <= S_DONE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_readout_sequencer.sv
// Randomised frame-level bench for pixel_readout_sequencer against a frame/beat reference model.
module tb_pixel_readout_sequencer;

    localparam int unsigned H      = 4;
    localparam int unsigned W      = 16;
    localparam int unsigned PB     = 8;
    localparam int unsigned BUS    = 8;
    localparam int unsigned ECW    = 16;
    localparam int unsigned G      = W / BUS;
    localparam int unsigned ROW_W  = 2;
    localparam int unsigned GRP_W  = 1;
    localparam int unsigned DW     = BUS * PB;
`ifdef ROI_EN
    localparam bit HAS_ROI = 1'b1;
`else
    localparam bit HAS_ROI = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [ECW-1:0]   expose_cycles = '0;
    logic             erase, expose, convert, read_en;
    logic [PB-1:0]    adc_count;
    logic [ROW_W-1:0] row_select;
    logic [GRP_W-1:0] col_group;
    logic [DW-1:0]    pix_data, out_data;
    logic             out_valid, out_sof, out_eol, out_eof, busy, frame_done;
    logic             out_ready = 1'b1;
`ifdef ROI_EN
    logic [ROW_W-1:0] roi_row_first = '0, roi_row_last = '0;
    logic [GRP_W-1:0] roi_grp_first = '0, roi_grp_last = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned seed = 0;

    always #5 clk = ~clk;

    pixel_readout_sequencer #(
        .PIXEL_ARRAY_HEIGHT(H), .PIXEL_ARRAY_WIDTH(W), .PIXEL_BITS(PB),
        .OUTPUT_BUS_WIDTH(BUS), .EXPOSE_CNT_W(ECW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .expose_cycles(expose_cycles),
`ifdef ROI_EN
        .roi_row_first(roi_row_first), .roi_row_last(roi_row_last),
        .roi_grp_first(roi_grp_first), .roi_grp_last(roi_grp_last),
`endif
        .erase(erase), .expose(expose), .convert(convert), .adc_count(adc_count),
        .row_select(row_select), .col_group(col_group), .read_en(read_en),
        .pix_data(pix_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .busy(busy), .frame_done(frame_done)
    );

    // Pixel array model: every pixel value is a function of its address and a per-frame seed.
    function automatic logic [DW-1:0] pix_beat(input int unsigned r, input int unsigned g,
                                               input int unsigned s);
        logic [DW-1:0] v;
        for (int p = 0; p < BUS; p++) v[p*PB +: PB] = PB'(r * 37 + g * 11 + p * 5 + s);
        return v;
    endfunction

    always_comb pix_data = pix_beat(32'(row_select), 32'(col_group), seed);

    function automatic logic [63:0] ctl_vec();
        return 64'({erase, expose, convert, adc_count, row_select, col_group, read_en,
                    out_valid, out_sof, out_eol, out_eof, busy, frame_done});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // rmode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic run_frame(input int exp_cyc, input int rmode, input int abort_at,
                             input bit poke, input int rf, input int rl, input int gf,
                             input int gl);
        logic [DW-1:0] e_data[$];
        logic [2:0]    e_mk[$];
        logic [DW+2:0] prev_val;
        int erf, erl, egf, egl;
        int cyc, beat, first_c, last_c, done_c, exp_hi, conv_n, adc_err, stall_err;
        bit prev_stall, poked;

        seed = $urandom_range(0, 255);
        erf = 0; erl = H - 1; egf = 0; egl = G - 1;
        if (HAS_ROI && rf <= rl && rl < H && gf <= gl && gl < G) begin
            erf = rf; erl = rl; egf = gf; egl = gl;
        end
        for (int r = erf; r <= erl; r++)
            for (int g = egf; g <= egl; g++) begin
                e_data.push_back(pix_beat(r, g, seed));
                e_mk.push_back({(r == erf && g == egf), (g == egl), (r == erl && g == egl)});
            end

        @(posedge clk); #1;
        start = 1'b1;
        expose_cycles = ECW'(exp_cyc);
`ifdef ROI_EN
        roi_row_first = ROW_W'(rf); roi_row_last = ROW_W'(rl);
        roi_grp_first = GRP_W'(gf); roi_grp_last = GRP_W'(gl);
`endif
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;

        cyc = 0; beat = 0; first_c = -1; last_c = -1; done_c = -1;
        exp_hi = 0; conv_n = 0; adc_err = 0; stall_err = 0;
        prev_stall = 1'b0; poked = 1'b0; prev_val = '0;
        while (done_c < 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (abort_at >= 0 && beat == abort_at && out_valid) begin
                reset = 1'b1;
                #1;
                chk("abort_ctl", ctl_vec(), 64'd0);
                chk("abort_data", out_data, 64'd0);
                #3;
                reset = 1'b0;
                return;
            end
            if (expose) exp_hi++;
            if (convert) begin
                if (adc_count != PB'(conv_n)) adc_err++;
                conv_n++;
            end else if (adc_count != '0) begin
                adc_err++;
            end
            if (prev_stall && {out_data, out_sof, out_eol, out_eof} != prev_val) stall_err++;
            if (out_valid && !out_ready && read_en) stall_err++;
            if (out_valid && out_ready) begin
                if (beat < e_data.size()) begin
                    chk("beat_data", out_data, e_data[beat]);
                    chk("beat_markers", 64'({out_sof, out_eol, out_eof}), 64'(e_mk[beat]));
                end else begin
                    chk("extra_beat", 64'(beat), 64'(e_data.size()));
                end
                if (beat == 0) first_c = cyc;
                last_c = cyc;
                beat++;
            end
            prev_stall = out_valid && !out_ready;
            prev_val   = {out_data, out_sof, out_eol, out_eof};
            if (frame_done) done_c = cyc;
            if (poke && ((expose && !poked) || frame_done)) begin
                start = 1'b1;
                poked = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            case (rmode)
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end

        chk("frame_done_seen", 64'(done_c >= 0), 64'd1);
        chk("beat_count", 64'(beat), 64'(e_data.size()));
        chk("done_latency", 64'(done_c), 64'(last_c + 1));
        chk("expose_len", 64'(exp_hi), 64'((exp_cyc == 0) ? 1 : exp_cyc));
        chk("convert_len", 64'(conv_n), 64'(1 << PB));
        chk("adc_ramp", 64'(adc_err), 64'd0);
        chk("stall_hold", 64'(stall_err), 64'd0);
        if (rmode == 0) chk("no_bubble", 64'(last_c - first_c), 64'(beat - 1));
        out_ready = 1'b1;
        @(negedge clk);
        chk("done_pulse", 64'({frame_done, busy}), 64'd0);
        repeat (4) @(negedge clk);
        chk("idle_hold", 64'(busy), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ctl", ctl_vec(), 64'd0);
        chk("reset_data", out_data, 64'd0);
        reset = 1'b0;

        run_frame(0, 0, -1, 1'b0, 0, 0, 0, 0);
        run_frame(5, 1, -1, 1'b1, 0, 0, 0, 0);
        repeat (2) run_frame(int'($urandom_range(0, 9)), 2, -1, 1'b0, 0, 0, 0, 0);
        run_frame(3, 0, 2, 1'b0, 0, 0, 0, 0);
        run_frame(1, 0, -1, 1'b0, 0, 0, 0, 0);
        run_frame(2, 0, -1, 1'b0, 1, 2, 1, 1);
        run_frame(2, 1, -1, 1'b0, 2, 1, 0, 1);
        run_frame(4, 2, -1, 1'b0, 0, 3, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_readout_sequencer.md
Name: pixel_readout_sequencer

Overview:
- Parametrised frame sequencer for the pixel sensor array. Runs one full capture per start pulse: erase, expose, ADC ramp conversion, then row/column-group readout.
- Streams OUTPUT_BUS_WIDTH pixels per beat downstream over a valid/ready handshake, with frame and line markers.
- Successor to the fixed 128x128 / 8-pixel-bus configuration: array geometry, pixel depth, bus width and exposure time are all generic.

Parameters:
- PIXEL_ARRAY_HEIGHT, 128, rows in the array.
- PIXEL_ARRAY_WIDTH, 128, columns in the array; must be a multiple of OUTPUT_BUS_WIDTH, otherwise elaboration fails with $error.
- PIXEL_BITS, 8, bits per pixel and ADC ramp width.
- OUTPUT_BUS_WIDTH, 8, pixels per output beat.
- EXPOSE_CNT_W, 16, width of the exposure-time input.
- Derived: ROW_W = $clog2(PIXEL_ARRAY_HEIGHT); GROUPS = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH; GRP_W = max(1, $clog2(GROUPS)).

Ports:
- clk  in  1  main clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle capture request; sampled only in IDLE.
- expose_cycles  in  EXPOSE_CNT_W  exposure length; latched on an accepted start.
- erase  out  1  array erase strobe.
- expose  out  1  array expose enable.
- convert  out  1  ADC compare enable.
- adc_count  out  PIXEL_BITS  ramp code broadcast to the array.
- row_select  out  ROW_W  row being read.
- col_group  out  GRP_W  column group being read.
- read_en  out  1  array drives pix_data for {row_select, col_group} this cycle.
- pix_data  in  OUTPUT_BUS_WIDTH*PIXEL_BITS  array read data, combinational from the address.
- out_data  out  OUTPUT_BUS_WIDTH*PIXEL_BITS  registered pixel beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- out_sof  out  1  first beat of the frame; qualified by out_valid.
- out_eol  out  1  last beat of a row; qualified by out_valid.
- out_eof  out  1  last beat of the frame; qualified by out_valid.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE. Reset asserted mid-frame aborts immediately. A held out_valid beat is dropped.
- FSM transitions:
  - IDLE -> ERASE on start.
  - ERASE, 1 cycle, erase=1 -> EXPOSE.
  - EXPOSE: expose=1 for max(expose_cycles,1) cycles -> CONVERT.
  - CONVERT: convert=1 for 2^PIXEL_BITS cycles; adc_count = 0, 1, ..., 2^PIXEL_BITS-1, one step per cycle -> READ.
  - READ -> DONE after the final beat is accepted.
  - DONE, 1 cycle, frame_done=1 -> IDLE.
- adc_count is 0 outside CONVERT.
- start is ignored when busy=1, including the DONE cycle.
- READ scan order: row-major. col_group increments first and wraps at GROUPS-1; row_select increments on each col_group wrap.
- One-deep output register:
  - Empty when out_valid=0; "accepted" means out_valid && out_ready.
  - read_en=1 and the address advances in any READ cycle where the register is empty or being accepted and addresses remain.
  - pix_data is captured into out_data with out_valid=1 on the next edge, so latency is 1 cycle from read_en to out_valid.
- Throughput: with out_ready held at 1, one beat per cycle and no bubbles.
- Backpressure: out_valid=1 and out_ready=0 holds out_data and the markers stable, and read_en stays 0.
- Markers, registered with the beat:
  - out_sof on row 0, group 0.
  - out_eol when group = GROUPS-1.
  - out_eof on the last row's last group.
  - Single-group array: every beat has out_eol=1.
- Beats per frame = PIXEL_ARRAY_HEIGHT*GROUPS.
- out_valid drops when the final beat is accepted; DONE follows in the next cycle.
- All counters are sized to the derived widths and never exceed their terminal counts.

Optional Feature:
- Macro: ROI_EN.
- Defined:
  - Adds inputs roi_row_first, roi_row_last (ROW_W each) and roi_grp_first, roi_grp_last (GRP_W each), latched on an accepted start.
  - READ scans only the rectangle first..last inclusive. The markers refer to the ROI: sof on the first ROI beat, eol on roi_grp_last, eof on the last ROI beat.
  - If first>last, or last exceeds the array, the full frame is used instead.
- Undefined: ports absent, full frame always scanned.

Test Plan:
- Full frame, ready=1, H=4, W=16, BUS=8 -> 8 beats in 8 consecutive cycles. sof on beat 0; eol on beats 1,3,5,7; eof on beat 7; frame_done 1 cycle after beat 7.
- ready toggled 1,0,0,1 repeatedly -> no beat lost or duplicated, out_data stable while stalled, read_en=0 during the stall.
- expose_cycles=0 then 5 -> expose high for exactly 1 then 5 cycles; convert high for 256 cycles with adc_count 0..255 at PIXEL_BITS=8.
- start pulsed during EXPOSE and on the DONE cycle -> ignored; exactly one frame produced.
- reset asserted on the 3rd READ beat -> all outputs 0 the same cycle; a new start yields a clean frame beginning with sof.
- ROI_EN, rows 1..2, groups 1..1 -> 2 beats; sof+eol on the first, eol+eof on the second.
